// File: rtl/cf_math_pkg.sv
// Small math helpers shared by parameter derivations.
//   idx_width(n): bits needed to index n items, minimum 1.
package cf_math_pkg;

  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/croc_pkg.sv
// SoC-level types: OBI subordinate port and register-interface payloads.
package croc_pkg;

  localparam int unsigned AddrWidth   = 32;
  localparam int unsigned DataWidth   = 32;
  localparam int unsigned StrbWidth   = DataWidth / 8;
  localparam int unsigned SbrAidWidth = 4;

  // Cycles a register slave may stall before the bridge aborts the access.
  localparam int unsigned RegBridgeTimeoutCycles = 32'd256;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [StrbWidth-1:0]   be;
    logic [DataWidth-1:0]   wdata;
    logic [SbrAidWidth-1:0] aid;
    logic                   a_optional;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    sbr_obi_a_chan_t a;
    logic            req;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [DataWidth-1:0]   rdata;
    logic [SbrAidWidth-1:0] rid;
    logic                   err;
    logic                   r_optional;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] wstrb;
    logic                 valid;
  } reg_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 ready;
  } reg_rsp_t;

endpackage

// File: rtl/croc_obi_reg_bridge.sv
// OBI subordinate to register-interface bridge, one transaction in flight.
// A stalled register slave is aborted after TimeoutCycles BUSY cycles and
// answered with an OBI error so the crossbar never deadlocks.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   obi_req_i      OBI request from crossbar
//   obi_rsp_o      OBI response (gnt combinational, r-channel from state)
//   reg_req_o      regbus request, valid only while BUSY
//   reg_rsp_i      regbus response
//   timeout_o      one-cycle pulse on a timeout abort
module croc_obi_reg_bridge
  import croc_pkg::*;
#(
  parameter type         obi_req_t     = croc_pkg::sbr_obi_req_t,
  parameter type         obi_rsp_t     = croc_pkg::sbr_obi_rsp_t,
  parameter type         reg_req_t     = croc_pkg::reg_req_t,
  parameter type         reg_rsp_t     = croc_pkg::reg_rsp_t,
  parameter int unsigned TimeoutCycles = croc_pkg::RegBridgeTimeoutCycles,
  parameter int unsigned CntWidth      = cf_math_pkg::idx_width(TimeoutCycles + 32'd1)
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output reg_req_t reg_req_o,
  input  reg_rsp_t reg_rsp_i,
  output logic     timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam bit                  TimeoutEn = (TimeoutCycles != 32'd0);
  localparam logic [CntWidth-1:0] CntLast   = CntWidth'(TimeoutCycles - 32'd1);

  state_e                 state_q, state_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   we_q, we_d;
  logic [StrbWidth-1:0]   be_q, be_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [SbrAidWidth-1:0] aid_q, aid_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   gnt;

  // a_optional carries nothing this bridge understands.
  logic unused_a_optional;
  assign unused_a_optional = obi_req_i.a.a_optional;

  // Next-state, latch updates and all bridge outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    aid_d     = aid_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    obi_rsp_o = '0;
    reg_req_o = '0;
    timeout_o = 1'b0;

    // Accept a new request whenever no access is outstanding at the slave.
    gnt           = obi_req_i.req && ((state_q == IDLE) || (state_q == RESP));
    obi_rsp_o.gnt = gnt;

    if (gnt) begin
      addr_d  = obi_req_i.a.addr;
      we_d    = obi_req_i.a.we;
      be_d    = obi_req_i.a.be;
      wdata_d = obi_req_i.a.wdata;
      aid_d   = obi_req_i.a.aid;
      cnt_d   = '0;
    end

    case (state_q)
      IDLE: begin
        if (gnt) state_d = BUSY;
      end
      BUSY: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.addr  = addr_q;
        reg_req_o.write = we_q;
        reg_req_o.wdata = wdata_q;
        reg_req_o.wstrb = we_q ? be_q : '0;
        // ready wins over a timeout in the same cycle
        if (reg_rsp_i.ready) begin
          rdata_d = we_q ? '0 : reg_rsp_i.rdata;
          err_d   = reg_rsp_i.error;
          state_d = RESP;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          timeout_o = 1'b1;
          state_d   = RESP;
        end else if (TimeoutEn && (cnt_q != '1)) begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      RESP: begin
        obi_rsp_o.rvalid  = 1'b1;
        obi_rsp_o.r.rdata = rdata_q;
        obi_rsp_o.r.rid   = aid_q;
        obi_rsp_o.r.err   = err_q;
        state_d           = gnt ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and latched transaction fields.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      aid_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      aid_q   <= aid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_croc_obi_reg_bridge.sv
// Directed bench for croc_obi_reg_bridge with a 4-cycle timeout.
module tb_croc_obi_reg_bridge;
  import croc_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  sbr_obi_req_t obi_req;
  sbr_obi_rsp_t obi_rsp;
  reg_req_t     reg_req;
  reg_rsp_t     reg_rsp;
  logic         timeout;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  croc_obi_reg_bridge #(
    .TimeoutCycles(32'd4)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .obi_req_i(obi_req),
    .obi_rsp_o(obi_rsp),
    .reg_req_o(reg_req),
    .reg_rsp_i(reg_rsp),
    .timeout_o(timeout)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [3:0] aid);
    obi_req         = '0;
    obi_req.req     = 1'b1;
    obi_req.a.addr  = addr;
    obi_req.a.we    = we;
    obi_req.a.be    = be;
    obi_req.a.wdata = wdata;
    obi_req.a.aid   = aid;
  endtask

  task automatic slave(input logic ready, input logic [31:0] rdata, input logic error);
    reg_rsp.ready = ready;
    reg_rsp.rdata = rdata;
    reg_rsp.error = error;
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] rdata, input logic [3:0] rid,
                         input logic err);
    check({tag, "_rvalid"}, 128'(obi_rsp.rvalid), 128'd1);
    check({tag, "_rdata"}, 128'(obi_rsp.r.rdata), 128'(rdata));
    check({tag, "_rid"}, 128'(obi_rsp.r.rid), 128'(rid));
    check({tag, "_err"}, 128'(obi_rsp.r.err), 128'(err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    obi_req = '0;
    reg_rsp = '0;
    #12;
    check("rst_obi_rsp", 128'(obi_rsp), 128'd0);
    check("rst_reg_req", 128'(reg_req), 128'd0);
    check("rst_timeout", 128'(timeout), 128'd0);
    rst_n = 1'b1;
    cyc();

    // 1: zero-wait read
    issue(32'h0300_2000, 1'b0, 4'hF, 32'h0, 4'd5);
    slave(1'b1, 32'hDEAD_BEEF, 1'b0);
    smp();
    check("t1_gnt", 128'(obi_rsp.gnt), 128'd1);
    check("t1_c0_valid", 128'(reg_req.valid), 128'd0);
    check("t1_c0_rvalid", 128'(obi_rsp.rvalid), 128'd0);
    cyc();
    obi_req = '0;
    smp();
    check("t1_c1_valid", 128'(reg_req.valid), 128'd1);
    check("t1_c1_addr", 128'(reg_req.addr), 128'h0300_2000);
    check("t1_c1_write", 128'(reg_req.write), 128'd0);
    check("t1_c1_wstrb", 128'(reg_req.wstrb), 128'd0);
    check("t1_c1_rvalid", 128'(obi_rsp.rvalid), 128'd0);
    cyc();
    smp();
    chk_rsp("t1_c2", 32'hDEAD_BEEF, 4'd5, 1'b0);
    check("t1_c2_valid", 128'(reg_req.valid), 128'd0);
    cyc();
    smp();
    check("t1_c3_rvalid", 128'(obi_rsp.rvalid), 128'd0);
    check("t1_c3_rdata", 128'(obi_rsp.r.rdata), 128'd0);
    cyc();

    // 2: write with three wait states
    issue(32'h0300_1004, 1'b1, 4'b0110, 32'h1234_5678, 4'd2);
    slave(1'b0, 32'h0, 1'b0);
    smp();
    check("t2_gnt", 128'(obi_rsp.gnt), 128'd1);
    cyc();
    obi_req = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) slave(1'b1, 32'hAAAA_5555, 1'b0);
      smp();
      check($sformatf("t2_valid%0d", i), 128'(reg_req.valid), 128'd1);
      check($sformatf("t2_addr%0d", i), 128'(reg_req.addr), 128'h0300_1004);
      check($sformatf("t2_wdata%0d", i), 128'(reg_req.wdata), 128'h1234_5678);
      check($sformatf("t2_wstrb%0d", i), 128'(reg_req.wstrb), 128'b0110);
      check($sformatf("t2_write%0d", i), 128'(reg_req.write), 128'd1);
      check($sformatf("t2_rvalid%0d", i), 128'(obi_rsp.rvalid), 128'd0);
      cyc();
    end
    slave(1'b0, 32'h0, 1'b0);
    smp();
    chk_rsp("t2_rsp", 32'h0, 4'd2, 1'b0);
    check("t2_rsp_valid", 128'(reg_req.valid), 128'd0);
    cyc();

    // 3: slave error on read
    issue(32'h0300_3008, 1'b0, 4'hF, 32'h0, 4'd7);
    slave(1'b1, 32'h0BAD_F00D, 1'b1);
    smp();
    check("t3_gnt", 128'(obi_rsp.gnt), 128'd1);
    cyc();
    obi_req = '0;
    smp();
    check("t3_valid", 128'(reg_req.valid), 128'd1);
    cyc();
    slave(1'b0, 32'h0, 1'b0);
    smp();
    chk_rsp("t3_rsp", 32'h0BAD_F00D, 4'd7, 1'b1);
    cyc();

    // 4a: slave never ready -> timeout in 4th BUSY cycle
    issue(32'h0300_4000, 1'b0, 4'hF, 32'h0, 4'd3);
    slave(1'b0, 32'hFFFF_FFFF, 1'b0);
    smp();
    check("t4a_gnt", 128'(obi_rsp.gnt), 128'd1);
    cyc();
    obi_req = '0;
    for (int i = 0; i < 4; i++) begin
      smp();
      check($sformatf("t4a_valid%0d", i), 128'(reg_req.valid), 128'd1);
      check($sformatf("t4a_timeout%0d", i), 128'(timeout), (i == 3) ? 128'd1 : 128'd0);
      cyc();
    end
    smp();
    chk_rsp("t4a_rsp", 32'h0, 4'd3, 1'b1);
    check("t4a_rsp_valid", 128'(reg_req.valid), 128'd0);
    check("t4a_rsp_timeout", 128'(timeout), 128'd0);
    cyc();

    // 4b: ready in the timeout cycle wins
    issue(32'h0300_4004, 1'b0, 4'hF, 32'h0, 4'd4);
    slave(1'b0, 32'h0, 1'b0);
    smp();
    check("t4b_gnt", 128'(obi_rsp.gnt), 128'd1);
    cyc();
    obi_req = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) slave(1'b1, 32'h55AA_33CC, 1'b0);
      smp();
      check($sformatf("t4b_valid%0d", i), 128'(reg_req.valid), 128'd1);
      check($sformatf("t4b_timeout%0d", i), 128'(timeout), 128'd0);
      cyc();
    end
    slave(1'b0, 32'h0, 1'b0);
    smp();
    chk_rsp("t4b_rsp", 32'h55AA_33CC, 4'd4, 1'b0);
    cyc();

    // 5: back-to-back, request held high, zero-wait slave
    slave(1'b1, 32'hCAFE_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      issue(32'h0300_5000 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 4'(i + 1));
      smp();
      check($sformatf("t5_gnt%0d", i), 128'(obi_rsp.gnt), 128'd1);
      if (i == 0) begin
        check("t5_rvalid_first", 128'(obi_rsp.rvalid), 128'd0);
      end else begin
        chk_rsp($sformatf("t5_rsp%0d", i - 1), 32'hCAFE_0000, 4'(i), 1'b0);
      end
      cyc();
      smp();
      check($sformatf("t5_busy_gnt%0d", i), 128'(obi_rsp.gnt), 128'd0);
      check($sformatf("t5_busy_valid%0d", i), 128'(reg_req.valid), 128'd1);
      check($sformatf("t5_busy_addr%0d", i), 128'(reg_req.addr), 128'(32'h0300_5000 + 32'(4 * i)));
      check($sformatf("t5_busy_rvalid%0d", i), 128'(obi_rsp.rvalid), 128'd0);
      cyc();
    end
    obi_req = '0;
    smp();
    chk_rsp("t5_rsp2", 32'hCAFE_0000, 4'd3, 1'b0);
    check("t5_last_gnt", 128'(obi_rsp.gnt), 128'd0);
    cyc();
    smp();
    check("t5_idle_rvalid", 128'(obi_rsp.rvalid), 128'd0);
    cyc();

    // 6: reset during a wait state, then a fresh read
    slave(1'b0, 32'h0, 1'b0);
    issue(32'h0300_6000, 1'b0, 4'hF, 32'h0, 4'd6);
    smp();
    check("t6_gnt", 128'(obi_rsp.gnt), 128'd1);
    cyc();
    obi_req = '0;
    smp();
    check("t6_valid_pre", 128'(reg_req.valid), 128'd1);
    cyc();
    rst_n = 1'b0;
    #1;
    check("t6_rst_reg_req", 128'(reg_req), 128'd0);
    check("t6_rst_obi_rsp", 128'(obi_rsp), 128'd0);
    check("t6_rst_timeout", 128'(timeout), 128'd0);
    cyc();
    rst_n = 1'b1;
    smp();
    check("t6_post_rvalid", 128'(obi_rsp.rvalid), 128'd0);
    check("t6_post_valid", 128'(reg_req.valid), 128'd0);
    cyc();
    issue(32'h0300_2004, 1'b0, 4'hF, 32'h0, 4'd9);
    slave(1'b1, 32'h600D_F00D, 1'b0);
    smp();
    check("t6_new_gnt", 128'(obi_rsp.gnt), 128'd1);
    cyc();
    obi_req = '0;
    smp();
    check("t6_new_valid", 128'(reg_req.valid), 128'd1);
    check("t6_new_addr", 128'(reg_req.addr), 128'h0300_2004);
    cyc();
    smp();
    chk_rsp("t6_new_rsp", 32'h600D_F00D, 4'd9, 1'b0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
